// File: rtl/rng_harvester_if.sv
// CPU-side read port of the RNG harvester FIFO.
// The harvester drives the FWFT head, empty flag and occupancy; the reader pops.
interface rng_harvester_if #(
  parameter int OUT_W = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             rng_rd_en;
  logic [OUT_W-1:0] rng_data;
  logic             rng_empty;
  logic [CW-1:0]    rng_count;

  modport master (
    input  rng_rd_en,
    output rng_data,
    output rng_empty,
    output rng_count
  );

  modport slave (
    output rng_rd_en,
    input  rng_data,
    input  rng_empty,
    input  rng_count
  );
endinterface

// File: rtl/rng_harvester.sv
// Harvests entropy from reduced-latency RNG reads, packs it into words
// and buffers them in a first-word-fall-through FIFO for the CPU.
module rng_harvester #(
  parameter int              DATA_W      = 256,
  parameter logic [DATA_W-1:0] PATTERN   = {DATA_W{1'b1}},
  parameter int              HARV_W      = 8,
  parameter int              OUT_W       = 32,
  parameter int              DEPTH       = 8,
  parameter int              FULL_MARGIN = 1,
  parameter int              MAX_OUTST   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              per_rng_rden,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rng_fifo_full,
  output logic [15:0]       drop_cnt,
  output logic              outst_err,
  rng_harvester_if.master   rif
);
  localparam int NL = DATA_W / HARV_W;
  localparam int N  = OUT_W / HARV_W;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  localparam logic [BW-1:0] LAST  = BW'(N - 1);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);
  localparam logic [CW-1:0] THR   = CW'(DEPTH - FULL_MARGIN);
  localparam logic [OW-1:0] OMAX  = OW'(MAX_OUTST);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t            state;
  logic [OW-1:0]     outst;
  logic [OUT_W-1:0]  shreg;
  logic [BW-1:0]     beat;
  logic [OUT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [DATA_W-1:0] x;
  logic [HARV_W-1:0] h;
  logic [OUT_W-1:0]  word_next;
  logic              hit;
  logic              harvest;
  logic              push;
  logic              pop_ok;
  logic              full_now;
  logic              push_ok;
  logic              drop;

  // XOR-fold the deviation from the written pattern into one lane
  always_comb begin
    x = rd_data ^ PATTERN;
    h = '0;
    for (int k = 0; k < NL; k++) begin
      h = h ^ x[k*HARV_W +: HARV_W];
    end
  end

  assign hit       = rd_valid & enable & (outst != '0);
  assign harvest   = hit & (state == COLLECT) & ~flush;
  assign word_next = {shreg[OUT_W-HARV_W-1:0], h};
  assign push      = harvest & (beat == LAST);
  assign full_now  = (count == CFULL);
  assign pop_ok    = rif.rng_rd_en & (count != '0) & ~flush;
  assign push_ok   = push & (~full_now | pop_ok);
  assign drop      = push & full_now & ~pop_ok;

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (enable) state <= COLLECT;
        COLLECT: if (!enable) state <= (beat != '0) ? HOLD : IDLE;
        HOLD:    if (enable) state <= COLLECT;
        default: state <= IDLE;
      endcase
    end
  end

  // A read issued and a read returned in the same cycle cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      outst     <= '0;
      outst_err <= 1'b0;
    end else if (flush) begin
      outst <= '0;
    end else begin
      unique case ({per_rng_rden, hit})
        2'b10: begin
          if (outst == OMAX) outst_err <= 1'b1;
          else               outst     <= outst + 1'b1;
        end
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      shreg <= '0;
      beat  <= '0;
    end else if (harvest) begin
      shreg <= word_next;
      beat  <= (beat == LAST) ? '0 : beat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= word_next;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      rng_fifo_full <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      count         <= count_next;
      rng_fifo_full <= (count_next >= THR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign rif.rng_empty = (count == '0);
  assign rif.rng_count = count;
  assign rif.rng_data  = (count != '0) ? mem[rptr] : '0;
endmodule

// File: tb/tb_rng_harvester.sv
// Directed bench for rng_harvester: packing, filtering, FIFO full/drop,
// HOLD behaviour, flush and outstanding overflow.
module tb_rng_harvester;
  localparam int DATA_W = 256;
  localparam logic [DATA_W-1:0] PAT = {DATA_W{1'b1}};

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              flush;
  logic              per_rng_rden;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rng_fifo_full;
  logic [15:0]       drop_cnt;
  logic              outst_err;

  int errors = 0;
  int checks = 0;

  rng_harvester_if #(.OUT_W(32), .DEPTH(8)) rif ();

  rng_harvester dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .flush         (flush),
    .per_rng_rden  (per_rng_rden),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rng_fifo_full (rng_fifo_full),
    .drop_cnt      (drop_cnt),
    .outst_err     (outst_err),
    .rif           (rif.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rden(input int n);
    per_rng_rden = 1'b1;
    repeat (n) cyc();
    per_rng_rden = 1'b0;
  endtask

  task automatic lanes(input logic [7:0] v);
    rd_data = PAT ^ {32{v}};
  endtask

  task automatic beat(input logic [7:0] v);
    rd_data  = PAT ^ {{(DATA_W-8){1'b0}}, v};
    rd_valid = 1'b1;
    cyc();
    rd_valid = 1'b0;
  endtask

  task automatic word(input logic [7:0] b, input logic pop_last);
    rden(4);
    beat(b);
    beat(b);
    beat(b);
    rif.rng_rd_en = pop_last;
    beat(b);
    rif.rng_rd_en = 1'b0;
  endtask

  task automatic pop();
    rif.rng_rd_en = 1'b1;
    cyc();
    rif.rng_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0;
    per_rng_rden = 1'b1; rd_valid = 1'b1; rd_data = '0;
    rif.rng_rd_en = 1'b0;
    #1;
    cyc();
    cyc();
    rst = 1'b0; per_rng_rden = 1'b0; rd_valid = 1'b0;
    check("rst_empty", 32'(rif.rng_empty), 32'd1);
    check("rst_count", 32'(rif.rng_count), 32'd0);
    check("rst_drop",  32'(drop_cnt), 32'd0);
    check("rst_err",   32'(outst_err), 32'd0);
    check("rst_full",  32'(rng_fifo_full), 32'd0);
    check("rst_data",  rif.rng_data, 32'd0);

    // all-lanes patterns fold to zero
    enable = 1'b1;
    cyc();
    rden(4);
    check("outst4", 32'(dut.outst), 32'd4);
    rd_valid = 1'b1;
    lanes(8'hA5); cyc();
    lanes(8'h3C); cyc();
    lanes(8'h00); cyc();
    check("empty_b3", 32'(rif.rng_empty), 32'd1);
    lanes(8'hFF); cyc();
    rd_valid = 1'b0;
    check("w0_empty", 32'(rif.rng_empty), 32'd0);
    check("w0_count", 32'(rif.rng_count), 32'd1);
    check("w0_data",  rif.rng_data, 32'h0000_0000);
    check("outst0",   32'(dut.outst), 32'd0);
    pop();
    check("w0_pop", 32'(rif.rng_empty), 32'd1);

    rden(4);
    beat(8'h01); beat(8'h01); beat(8'h01);
    check("w1_pre", 32'(rif.rng_empty), 32'd1);
    beat(8'h01);
    check("w1_data", rif.rng_data, 32'h0101_0101);
    pop();

    // non-RNG read, then issue+return in one cycle
    beat(8'h77);
    check("nonrng_cnt", 32'(rif.rng_count), 32'd0);
    check("nonrng_out", 32'(dut.outst), 32'd0);
    rden(1);
    per_rng_rden = 1'b1;
    beat(8'h11);
    per_rng_rden = 1'b0;
    check("both_outst", 32'(dut.outst), 32'd1);
    beat(8'h22);
    rden(2);
    beat(8'h33);
    beat(8'h44);
    check("filt_data", rif.rng_data, 32'h1122_3344);
    pop();

    // fill, full flag, drop, push+pop at full
    for (int k = 1; k <= 6; k++) word(8'(k), 1'b0);
    check("full6", 32'(rng_fifo_full), 32'd0);
    word(8'h07, 1'b0);
    check("full7", 32'(rng_fifo_full), 32'd1);
    check("cnt7",  32'(rif.rng_count), 32'd7);
    word(8'h08, 1'b0);
    check("cnt8",  32'(rif.rng_count), 32'd8);
    word(8'h09, 1'b0);
    check("drop1", 32'(drop_cnt), 32'd1);
    check("cnt8d", 32'(rif.rng_count), 32'd8);
    check("head1", rif.rng_data, 32'h0101_0101);
    word(8'h0A, 1'b1);
    check("cnt8pp", 32'(rif.rng_count), 32'd8);
    check("drop1pp", 32'(drop_cnt), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      check("drain", rif.rng_data, {4{8'(k)}});
      pop();
    end
    check("tail", rif.rng_data, 32'h0A0A_0A0A);
    pop();
    check("drained", 32'(rif.rng_empty), 32'd1);
    check("full_clr", 32'(rng_fifo_full), 32'd0);

    // partial word held across enable=0
    rden(4);
    beat(8'hB1);
    beat(8'hB2);
    enable = 1'b0;
    cyc();
    beat(8'hEE);
    check("hold_out", 32'(dut.outst), 32'd2);
    check("hold_cnt", 32'(rif.rng_count), 32'd0);
    enable = 1'b1;
    cyc();
    beat(8'hB3);
    beat(8'hB4);
    check("hold_cnt1", 32'(rif.rng_count), 32'd1);
    check("hold_data", rif.rng_data, 32'hB1B2_B3B4);

    rden(3);
    check("pre_flush", 32'(dut.outst), 32'd3);
    flush = 1'b1;
    rd_valid = 1'b1;
    cyc();
    flush = 1'b0;
    rd_valid = 1'b0;
    check("fl_count", 32'(rif.rng_count), 32'd0);
    check("fl_empty", 32'(rif.rng_empty), 32'd1);
    check("fl_outst", 32'(dut.outst), 32'd0);
    check("fl_drop",  32'(drop_cnt), 32'd1);

    // packer restarts cleanly after flush
    rden(4);
    beat(8'hC1); beat(8'hC2); beat(8'hC3); beat(8'hC4);
    check("fl_word", rif.rng_data, 32'hC1C2_C3C4);
    pop();

    // outstanding overflow
    enable = 1'b0;
    rden(4);
    check("ov_pre", 32'(outst_err), 32'd0);
    rden(1);
    check("ov_err",   32'(outst_err), 32'd1);
    check("ov_outst", 32'(dut.outst), 32'd4);
    cyc();
    cyc();
    check("ov_sticky", 32'(outst_err), 32'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("ov_fl_err", 32'(outst_err), 32'd1);
    check("ov_fl_out", 32'(dut.outst), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rng_harvester.md
Name: rng_harvester

Overview:
- Sits directly downstream of the reduced-latency-read (RLRD) scheduler in the PiDRAM memory controller.
- Counts the RNG reads the scheduler issues (per_rng_rden) and matches each one to the read data returned by the PHY.
- Extracts entropy by XORing the returned data with the known written pattern and XOR-folding the result. Packs the harvested bits into OUT_W words and buffers them in a FWFT FIFO.
- Drives rng_fifo_full back to the scheduler, which uses it to end boost mode. A CPU-side reader drains the FIFO.

Parameters:
DATA_W, 256, width of one read burst returned by the PHY
PATTERN, {DATA_W{1'b1}}, value written to the RNG cells; XORed out of the read data
HARV_W, 8, bits harvested per read; DATA_W must be a multiple of HARV_W
OUT_W, 32, FIFO word width; must be a multiple of HARV_W
DEPTH, 8, FIFO depth in words; power of two
FULL_MARGIN, 1, number of free slots still remaining when rng_fifo_full asserts
MAX_OUTST, 4, maximum outstanding RNG reads

Ports:
clk  in  1  controller fabric clock
rst  in  1  synchronous active-high reset
enable  in  1  harvesting enable; when 0, rd_valid is ignored
flush  in  1  clears the FIFO, the packer and the outstanding counter
per_rng_rden  in  1  one-cycle pulse from the scheduler: an RNG read was issued
rd_valid  in  1  PHY read data valid (also asserted for non-RNG reads)
rd_data  in  DATA_W  PHY read data
rng_fifo_full  out  1  to the scheduler: FIFO count >= DEPTH-FULL_MARGIN
rng_rd_en  in  1  pop request from the CPU side
rng_data  out  OUT_W  FIFO head word (FWFT)
rng_empty  out  1  FIFO empty
rng_count  out  $clog2(DEPTH+1)  FIFO occupancy
drop_cnt  out  16  words dropped because the FIFO was full; saturates at 16'hFFFF
outst_err  out  1  sticky error flag: per_rng_rden pulsed with the outstanding count at MAX_OUTST

Behaviour:
- Reset (rst=1 at posedge) values: FIFO empty, rng_count=0, rng_empty=1, rng_fifo_full=0 (assuming DEPTH > FULL_MARGIN), rng_data=0, drop_cnt=0, outst_err=0, outstanding=0, packer cleared, FSM in IDLE.
- flush: same effect as rst, except drop_cnt and outst_err are held. flush takes priority over every other input in the same cycle.
- Outstanding counter (width $clog2(MAX_OUTST+1)):
  - per_rng_rden alone: +1. If the counter is already at MAX_OUTST, it holds and outst_err is set.
  - An RNG hit (rd_valid & enable & outstanding!=0) alone: -1.
  - Both in the same cycle: unchanged.
  - rd_valid with outstanding==0 is a non-RNG read and is ignored.
- Harvest: h = XOR over k of (rd_data^PATTERN)[k*HARV_W +: HARV_W], for k = 0..DATA_W/HARV_W-1. Purely combinational; consumed on the RNG hit cycle.
- Packer:
  - Shift register plus beat counter, N = OUT_W/HARV_W beats per word.
  - On each hit: shreg <= {shreg[OUT_W-HARV_W-1:0], h}.
  - On the Nth hit, the word {shreg[OUT_W-HARV_W-1:0], h} is pushed at that same posedge and the beat counter wraps to 0.
  - Latency: the Nth rd_valid at cycle t gives rng_empty=0 and rng_count+1 from cycle t+1.
- FSM (registered state):
  - IDLE: enter COLLECT when enable=1.
  - COLLECT: harvest hits. When enable=0 and the beat counter != 0, go to HOLD; when enable=0 and the beat counter == 0, go to IDLE.
  - HOLD: keep the partial word and ignore hits. When enable=1, return to COLLECT.
  - flush sends any state to IDLE.
  - Outstanding tracking runs in every state.
- FIFO:
  - FWFT: rng_data is the head word while rng_empty=0, else 0.
  - A pop with rng_rd_en=1 and rng_empty=1 is ignored.
  - A push when full with no simultaneous pop drops the word and increments drop_cnt (saturating).
  - Push and pop in the same cycle when full: both take effect, count unchanged.
  - Push and pop in the same cycle when empty: the push takes effect and the pop is ignored.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- rng_fifo_full is registered from the next count, so it asserts in the same cycle the count reaches the threshold. FULL_MARGIN absorbs reads still in flight when the scheduler sees full.

Test Plan:
- Reset: assert rst for 2 cycles with rd_valid=1 and per_rng_rden=1 -> rng_empty=1, rng_count=0, drop_cnt=0, outst_err=0, rng_fifo_full=0.
- Basic word: enable=1, 4 pulses of per_rng_rden, then 4 rd_valid with rd_data=PATTERN^{32 copies of 8'hA5}, {8'h3C}, {8'h00}, {8'hFF}, each 32 copies XOR-folding to 0 -> expected h=00,00,00,00 and rng_data=32'h0000_0000. Repeat with one lane of 8'h01 in each beat -> rng_data=32'h0101_0101, appearing 1 cycle after the 4th rd_valid.
- Non-RNG filtering: rd_valid with outstanding=0 -> packer and FIFO unchanged. per_rng_rden and rd_valid in the same cycle with outstanding=1 -> outstanding stays 1 and one beat is harvested.
- Full/drop: DEPTH=8, FULL_MARGIN=1, fill 7 words -> rng_fifo_full=1 at count 7. Push 1 more -> count=8. Push a 9th word with no pop -> drop_cnt=1, count=8. Push and pop in the same cycle at full -> count=8, new word becomes the tail.
- HOLD/flush: enable=1, 2 hits, enable=0 -> state HOLD and further hits ignored; enable=1 and 2 more hits -> exactly one word pushed. Assert flush with outstanding=3 -> count=0, outstanding=0, drop_cnt retained.
- Outstanding overflow: 5 pulses of per_rng_rden with no rd_valid, MAX_OUTST=4 -> outst_err=1 (sticky), outstanding=4.
